// File: rtl/dac_spi_multi.sv
// dac_spi_multi: multi-channel serial DAC write engine.
// Latches NUM_CH words on a start strobe and shifts each enabled channel
// out MSB first as its own SYNC-framed SPI word, channel 0 first.
// Optional feature macro: DAC_SPI_DAISY_EN. When defined, all enabled
// channels go out back to back in a single SYNC frame, highest channel first.
//
// Handshake: i_start is a one-cycle request and is taken only while o_busy=0
// (IDLE or DONE). Every accepted request ends with exactly one o_done pulse,
// including a request with an empty channel mask.
module dac_spi_multi #(
    parameter int   DATA_W  = 16,
    parameter int   NUM_CH  = 4,
    parameter int   DIV_W   = 32,
    parameter logic CPOL    = 1'b1,
    parameter int   GAP_CYC = 4,
    localparam int  CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_ch_mask,
    input  logic [DIV_W-1:0]         i_sclk_div,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CH_W-1:0]          o_cur_ch,
    output logic                     o_sync,
    output logic                     o_sclk,
    output logic                     o_din,
    output logic [2:0]               o_state
);

    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LEAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TRAIL = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t                    r_state;
    logic [NUM_CH*DATA_W-1:0]  r_data;
    logic [NUM_CH-1:0]         r_mask;
    logic [DIV_W-1:0]          r_h;
    logic [DIV_W-1:0]          r_div;
    logic [BIT_W-1:0]          r_bit;
    logic [DATA_W-1:0]         r_shreg;
    logic [CH_W-1:0]           r_cur_ch;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_sync;
    logic                      r_sclk;
    logic                      r_din;

    logic [CH_W-1:0]           w_first_ch;
    logic [CH_W-1:0]           w_next_ch;
    logic                      w_more;
    logic [DATA_W-1:0]         w_cur_word;
    logic [DATA_W-1:0]         w_shift;
    logic [DIV_W-1:0]          w_h_in;
    logic [DIV_W-1:0]          w_hm1;
`ifdef DAC_SPI_DAISY_EN
    logic [DATA_W-1:0]         w_next_word;
`endif

    // A divider below 2 cannot give a distinct SCLK half period, so clamp it
    assign w_h_in  = (i_sclk_div < DIV_W'(2)) ? DIV_W'(2) : i_sclk_div;
    assign w_hm1   = r_h - DIV_W'(1);
    assign w_shift = r_shreg << 1;

    // Channel order: first channel of a new request and the one after r_cur_ch
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_more     = 1'b0;
`ifdef DAC_SPI_DAISY_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_ch_mask[k]) w_first_ch = CH_W'(k);
            if (r_mask[k] && (k < int'(r_cur_ch))) begin
                w_next_ch = CH_W'(k);
                w_more    = 1'b1;
            end
        end
`else
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (i_ch_mask[k]) w_first_ch = CH_W'(k);
            if (r_mask[k] && (k > int'(r_cur_ch))) begin
                w_next_ch = CH_W'(k);
                w_more    = 1'b1;
            end
        end
`endif
    end

    // Word of the channel currently selected
    always_comb begin
        w_cur_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == r_cur_ch) w_cur_word = r_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef DAC_SPI_DAISY_EN
    // Word of the channel that follows inside the same daisy frame
    always_comb begin
        w_next_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == w_next_ch) w_next_word = r_data[k*DATA_W +: DATA_W];
        end
    end
`endif

    // Transaction FSM with registered pin outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_mask   <= '0;
            r_h      <= DIV_W'(2);
            r_div    <= '0;
            r_bit    <= '0;
            r_shreg  <= '0;
            r_cur_ch <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sync   <= 1'b1;
            r_sclk   <= CPOL;
            r_din    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (i_start) begin
                        r_data   <= i_data;
                        r_mask   <= i_ch_mask;
                        r_h      <= w_h_in;
                        r_cur_ch <= w_first_ch;
                        if (i_ch_mask == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_shreg <= w_cur_word;
                    r_din   <= w_cur_word[DATA_W-1];
                    r_sync  <= 1'b0;
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_state <= ST_LEAD;
                end
                ST_LEAD: begin
                    if (r_div == w_hm1) begin
                        r_div   <= '0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (r_div == w_hm1) begin
                        r_div <= '0;
                        if (r_sclk == CPOL) begin
                            r_sclk <= ~CPOL;
                        end else begin
                            r_sclk <= CPOL;
                            if (r_bit == BIT_W'(DATA_W - 1)) begin
`ifdef DAC_SPI_DAISY_EN
                                if (w_more) begin
                                    r_shreg  <= w_next_word;
                                    r_din    <= w_next_word[DATA_W-1];
                                    r_cur_ch <= w_next_ch;
                                    r_bit    <= '0;
                                end else begin
                                    r_din   <= 1'b0;
                                    r_state <= ST_TRAIL;
                                end
`else
                                r_din   <= 1'b0;
                                r_state <= ST_TRAIL;
`endif
                            end else begin
                                r_shreg <= w_shift;
                                r_din   <= w_shift[DATA_W-1];
                                r_bit   <= r_bit + BIT_W'(1);
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_TRAIL: begin
                    if (r_div == w_hm1) begin
                        r_sync  <= 1'b1;
                        r_div   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_div == GAP_LAST) begin
                        r_div <= '0;
`ifdef DAC_SPI_DAISY_EN
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
`else
                        if (w_more) begin
                            r_cur_ch <= w_next_ch;
                            r_state  <= ST_LOAD;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
`endif
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_cur_ch = r_cur_ch;
    assign o_sync   = r_sync;
    assign o_sclk   = r_sclk;
    assign o_din    = r_din;
    assign o_state  = r_state;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Testbench for dac_spi_multi: table-driven transactions decoded from the
// DAC pins, plus hand-written reset, empty-mask and busy-start sequences.
module tb_dac_spi_multi;

    localparam int   DATA_W  = 16;
    localparam int   NUM_CH  = 4;
    localparam int   DIV_W   = 32;
    localparam logic CPOL    = 1'b1;
    localparam int   GAP_CYC = 4;
    localparam int   BUDGET  = 3000;

    typedef struct {
        logic [3:0]  mask;
        logic [63:0] data;
        logic [31:0] div;
        int          xs;
        int          nfr;
        logic [63:0] b0;
        int          n0;
        int          c0;
        logic [63:0] b1;
        int          n1;
        int          c1;
        int          len;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] data;
    logic [3:0]  ch_mask;
    logic [31:0] sclk_div;
    logic        busy, done, sync, sclk, din;
    logic [1:0]  cur_ch;
    logic [2:0]  state;

    always #5 clk = ~clk;

    dac_spi_multi #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .DIV_W   (DIV_W),
        .CPOL    (CPOL),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_data     (data),
        .i_ch_mask  (ch_mask),
        .i_sclk_div (sclk_div),
        .o_busy     (busy),
        .o_done     (done),
        .o_cur_ch   (cur_ch),
        .o_sync     (sync),
        .o_sclk     (sclk),
        .o_din      (din),
        .o_state    (state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    int          exp_n_q[$];
    int          exp_ch_q[$];

    logic [63:0] cap_bits[$];
    int          cap_nbits[$];
    int          cap_len[$];
    int          cap_ch[$];
    int          cap_chok[$];
    int          cap_gap[$];
    int          done_cnt, done_dist, sclk_bad, coll, din_bad, low_cnt;
    logic        first_busy, first_done;
    vec_t        vecs[$];
    vec_t        rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- driver + pin monitor ----------------
    task automatic run_txn(input logic [3:0] m, input logic [63:0] d, input logic [31:0] dv, input int xs);
        logic        psync, psclk;
        int          run_len, hi_run, nb, post, ch0, chok;
        logic [63:0] bits;
        cap_bits.delete(); cap_nbits.delete(); cap_len.delete();
        cap_ch.delete(); cap_chok.delete(); cap_gap.delete();
        done_cnt = 0; done_dist = -1; sclk_bad = 0; coll = 0; din_bad = 0; low_cnt = 0;
        psync = 1'b1; psclk = CPOL; run_len = 0; hi_run = 0; nb = 0; post = 0;
        ch0 = 0; chok = 1; bits = '0;
        @(negedge clk);
        ch_mask = m; data = d; sclk_div = dv; start = 1'b1;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                first_busy = busy;
                first_done = done;
            end
            if (k == 1) begin
                // latched values must not follow later input changes
                data = ~d; ch_mask = ~m; sclk_div = 32'd1;
            end
            if (k == xs) begin
                ch_mask = 4'hF; data = '1; start = 1'b1;
            end
            if (k == xs + 1) start = 1'b0;
            if ((sync !== psync) && (sclk !== psclk)) coll++;
            if ((sync === 1'b1) && (sclk !== CPOL)) sclk_bad++;
            if (sync === 1'b0) begin
                low_cnt++;
                if (psync === 1'b1) begin
                    if (cap_bits.size() > 0) cap_gap.push_back(hi_run + 1);
                    run_len = 0; bits = '0; nb = 0; ch0 = int'(cur_ch); chok = 1;
                end
                run_len++;
                if ((psclk === CPOL) && (sclk === ~CPOL)) begin
                    bits = {bits[62:0], din};
                    nb++;
                end
                if (int'(cur_ch) != ch0) chok = 0;
            end else begin
                if (psync === 1'b0) begin
                    cap_bits.push_back(bits); cap_nbits.push_back(nb);
                    cap_len.push_back(run_len); cap_ch.push_back(ch0);
                    cap_chok.push_back(chok);
                    if (din !== 1'b0) din_bad++;
                    hi_run = 0;
                end else begin
                    hi_run++;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_dist = hi_run;
            end
            psync = sync; psclk = sclk;
            if (done_cnt > 0) post++;
            if (post >= 6) break;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        logic [63:0] e;
        int          en, ec;
        run_txn(v.mask, v.data, v.div, v.xs);
        exp_q.delete(); exp_n_q.delete(); exp_ch_q.delete();
        if (v.nfr > 0) begin
            exp_q.push_back(v.b0); exp_n_q.push_back(v.n0); exp_ch_q.push_back(v.c0);
        end
        if (v.nfr > 1) begin
            exp_q.push_back(v.b1); exp_n_q.push_back(v.n1); exp_ch_q.push_back(v.c1);
        end
        check({tag, " done_seen"}, (done_cnt > 0) ? 1 : 0, 1);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_after_start"}, first_busy, 1);
        check({tag, " frames"}, cap_bits.size(), v.nfr);
        for (int f = 0; (f < cap_bits.size()) && (exp_q.size() > 0); f++) begin
            e  = exp_q.pop_front();
            en = exp_n_q.pop_front();
            ec = exp_ch_q.pop_front();
            check({tag, " word"}, cap_bits[f], e);
            check({tag, " edge_a_count"}, cap_nbits[f], en);
            check({tag, " cur_ch"}, cap_ch[f], ec);
            check({tag, " sync_low_len"}, cap_len[f], v.len);
`ifndef DAC_SPI_DAISY_EN
            check({tag, " cur_ch_stable"}, cap_chok[f], 1);
`endif
        end
        foreach (cap_gap[g]) check({tag, " gap_min"}, (cap_gap[g] >= GAP_CYC) ? 1 : 0, 1);
        check({tag, " done_after_rise"}, done_dist, GAP_CYC);
        check({tag, " sclk_idle_when_sync_high"}, sclk_bad, 0);
        check({tag, " sync_sclk_same_edge"}, coll, 0);
        check({tag, " din_zero_after_frame"}, din_bad, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int na;
        logic ps;
        rst = 1'b1; start = 1'b0; data = '0; ch_mask = '0; sclk_div = '0;

`ifdef DAC_SPI_DAISY_EN
        vecs.push_back('{4'b0011, 64'h0000_0000_1234_BEEF, 32'd3, -1, 1, 64'h1234_BEEF, 32, 1, 64'h0, 0, 0, 198});
        vecs.push_back('{4'b1010, 64'h4444_3333_2222_1111, 32'd2, -1, 1, 64'h4444_2222, 32, 3, 64'h0, 0, 0, 132});
        vecs.push_back('{4'b0001, 64'h0000_0000_0000_A5C3, 32'd4, 20, 1, 64'hA5C3, 16, 0, 64'h0, 0, 0, 136});
        vecs.push_back('{4'b0100, 64'h0000_3333_0000_0000, 32'd0, -1, 1, 64'h3333, 16, 2, 64'h0, 0, 0, 68});
`else
        vecs.push_back('{4'b0001, 64'h0000_0000_0000_A5C3, 32'd4, -1, 1, 64'hA5C3, 16, 0, 64'h0, 0, 0, 136});
        vecs.push_back('{4'b1010, 64'h4444_3333_2222_1111, 32'd4, -1, 2, 64'h2222, 16, 1, 64'h4444, 16, 3, 136});
        vecs.push_back('{4'b0001, 64'h0000_0000_0000_8001, 32'd0, 20, 1, 64'h8001, 16, 0, 64'h0, 0, 0, 68});
        vecs.push_back('{4'b0001, 64'h0000_0000_0000_7FFE, 32'd1, -1, 1, 64'h7FFE, 16, 0, 64'h0, 0, 0, 68});
        vecs.push_back('{4'b1100, 64'h0000_FFFF_0000_0000, 32'd3, -1, 2, 64'hFFFF, 16, 2, 64'h0000, 16, 3, 102});
        vecs.push_back('{4'b0101, 64'h0000_C0DE_0000_1357, 32'd2, -1, 2, 64'h1357, 16, 0, 64'hC0DE, 16, 2, 68});
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("reset sync", sync, 1'b1);
        check("reset sclk", sclk, CPOL);
        check("reset din", din, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset cur_ch", cur_ch, 2'd0);
        rst = 1'b0;

        // table of transactions
        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // empty channel mask: done one cycle after start, no frame
        run_txn(4'b0000, 64'h1234_5678_9ABC_DEF0, 32'd4, -1);
        check("mask0 done_next_cycle", first_done, 1'b1);
        check("mask0 busy_low", first_busy, 1'b0);
        check("mask0 done_count", done_cnt, 1);
        check("mask0 sync_low_cycles", low_cnt, 0);

        // reset in the middle of a frame, at bit 7
        @(negedge clk);
        ch_mask = 4'b0001; data = 64'h0000_0000_0000_A5C3; sclk_div = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        na = 0; ps = sclk;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if ((sync === 1'b0) && (ps === CPOL) && (sclk === ~CPOL)) na++;
            ps = sclk;
            if (na == 8) break;
        end
        check("midrst reached_bit7", na, 8);
        rst = 1'b1;
        @(negedge clk);
        check("midrst sync", sync, 1'b1);
        check("midrst sclk", sclk, CPOL);
        check("midrst din", din, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst cur_ch", cur_ch, 2'd0);
        rst = 1'b0;
        rv = '{4'b0001, 64'h0000_0000_0000_A5C3, 32'd4, -1, 1, 64'hA5C3, 16, 0, 64'h0, 0, 0, 136};
        apply_vec(rv, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
